data_checker: RTL and testbench

AXI4 write-only slave that terminates the 512-bit burst stream produced by the team's burst data generator and verifies it beat by beat. It receives each burst, checks that the data equals the generator's pattern (a 16-bit word replicated 32 times, incrementing by 1 per beat and starting at 1), and checks the burst framing. It reports results as status counters for the loopback and bring-up harness. It sits where the PCIe/RDMA destination would otherwise sit.

---
 rtl/data_checker.sv | 133 +++++++++++++
 tb/tb_data_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_checker.sv
// AXI4 write-only sink that checks the incrementing replicated-word burst pattern
// and keeps running statistics for the loopback / bring-up harness.
module data_checker (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  S_AXI_AWADDR,
  input  logic [7:0]   S_AXI_AWLEN,
  input  logic         S_AXI_AWVALID,
  output logic         S_AXI_AWREADY,
  input  logic [511:0] S_AXI_WDATA,
  input  logic [63:0]  S_AXI_WSTRB,
  input  logic         S_AXI_WLAST,
  input  logic         S_AXI_WVALID,
  output logic         S_AXI_WREADY,
  output logic [1:0]   S_AXI_BRESP,
  output logic         S_AXI_BVALID,
  input  logic         S_AXI_BREADY,
  input  logic         clear,
  output logic [63:0]  last_awaddr,
  output logic [31:0]  burst_count,
  output logic [31:0]  beat_count,
  output logic [31:0]  error_count,
  output logic [31:0]  first_err_beat,
  output logic [15:0]  first_err_data,
  output logic         error_seen
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t      state, state_next;
  logic [7:0]  beats_left;
  logic        burst_bad;
  logic [15:0] expected;
  logic        clear_pending;

  logic aw_hs, w_hs, b_hs, final_beat, beat_bad, clear_go;

  always_comb begin
    state_next = state;
    aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs       = S_AXI_WVALID && S_AXI_WREADY;
    b_hs       = S_AXI_BVALID && S_AXI_BREADY;
    final_beat = (beats_left == 8'd0);
    beat_bad   = (S_AXI_WDATA != {32{expected}}) ||
                 (S_AXI_WSTRB != {64{1'b1}}) ||
                 (S_AXI_WLAST != final_beat);
    // A clear only lands between bursts so in-flight checks are never disturbed.
    clear_go   = (clear || clear_pending) && (state == IDLE) && !aw_hs;
    case (state)
      IDLE:    if (aw_hs) state_next = DATA;
      DATA:    if (w_hs && final_beat) state_next = RESP;
      RESP:    if (b_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered copies decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
    end else begin
      state         <= state_next;
      S_AXI_AWREADY <= (state_next == IDLE);
      S_AXI_WREADY  <= (state_next == DATA);
      S_AXI_BVALID  <= (state_next == RESP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beats_left     <= 8'd0;
      burst_bad      <= 1'b0;
      S_AXI_BRESP    <= 2'b00;
      expected       <= 16'h0001;
      clear_pending  <= 1'b0;
      last_awaddr    <= 64'd0;
      burst_count    <= 32'd0;
      beat_count     <= 32'd0;
      error_count    <= 32'd0;
      first_err_beat <= 32'd0;
      first_err_data <= 16'd0;
      error_seen     <= 1'b0;
    end else begin
      if (aw_hs) begin
        beats_left  <= S_AXI_AWLEN;
        last_awaddr <= S_AXI_AWADDR;
        burst_bad   <= 1'b0;
      end

      if (w_hs) begin
        beat_count <= beat_count + 32'd1;
        expected   <= expected + 16'd1;
        if (!final_beat)
          beats_left <= beats_left - 8'd1;
        else
          S_AXI_BRESP <= (burst_bad || beat_bad) ? 2'b10 : 2'b00;
        if (beat_bad) begin
          burst_bad <= 1'b1;
          if (error_count != 32'hFFFF_FFFF)
            error_count <= error_count + 32'd1;
          if (!error_seen) begin
            error_seen     <= 1'b1;
            first_err_beat <= beat_count;
            first_err_data <= S_AXI_WDATA[15:0];
          end
        end
      end

      if (b_hs) begin
        burst_count <= burst_count + 32'd1;
        S_AXI_BRESP <= 2'b00;
      end

      if (clear_go) begin
        clear_pending  <= 1'b0;
        expected       <= 16'h0001;
        last_awaddr    <= 64'd0;
        burst_count    <= 32'd0;
        beat_count     <= 32'd0;
        error_count    <= 32'd0;
        first_err_beat <= 32'd0;
        first_err_data <= 16'd0;
        error_seen     <= 1'b0;
      end else if (clear) begin
        clear_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_checker.sv
// Directed bench for data_checker: a spec-level model is compared every cycle,
// and each scenario also pins hand-computed literal results.
module tb_data_checker;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid;
  logic         awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic         clear;
  logic [63:0]  last_awaddr;
  logic [31:0]  burst_count, beat_count, error_count, first_err_beat;
  logic [15:0]  first_err_data;
  logic         error_seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_checker dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .clear(clear), .last_awaddr(last_awaddr), .burst_count(burst_count), .beat_count(beat_count),
    .error_count(error_count), .first_err_beat(first_err_beat), .first_err_data(first_err_data),
    .error_seen(error_seen)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake never happened within 1000 cycles", name);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for address, 1 receiving beats, 2 holding response
  logic [1:0]  m_phase;
  int          m_len, m_idx;
  logic        m_bad;
  logic [1:0]  m_resp;
  logic [15:0] m_exp;
  logic [31:0] m_bursts, m_beats, m_errs, m_fbeat;
  logic [15:0] m_fdata;
  logic        m_seen, m_pend;
  logic [63:0] m_addr;

  logic t_aw, t_last, t_bad;
  assign t_aw   = awvalid && (m_phase == 2'd0);
  assign t_last = (m_idx == m_len);
  assign t_bad  = (wdata != {32{m_exp}}) || (wstrb != {64{1'b1}}) || (wlast != t_last);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 2'd0; m_len <= 0; m_idx <= 0; m_bad <= 1'b0; m_resp <= 2'd0;
      m_exp <= 16'd1; m_bursts <= 0; m_beats <= 0; m_errs <= 0; m_fbeat <= 0;
      m_fdata <= 0; m_seen <= 1'b0; m_pend <= 1'b0; m_addr <= 0;
    end else begin
      if (m_phase == 2'd0 && (clear || m_pend) && !t_aw) begin
        m_pend <= 1'b0; m_exp <= 16'd1; m_bursts <= 0; m_beats <= 0; m_errs <= 0;
        m_fbeat <= 0; m_fdata <= 0; m_seen <= 1'b0; m_addr <= 0;
      end else if (clear) begin
        m_pend <= 1'b1;
      end
      if (t_aw) begin
        m_phase <= 2'd1; m_len <= int'(awlen); m_idx <= 0; m_bad <= 1'b0; m_addr <= awaddr;
      end else if (m_phase == 2'd1 && wvalid) begin
        m_beats <= m_beats + 1;
        m_exp   <= m_exp + 16'd1;
        m_idx   <= m_idx + 1;
        if (t_bad) begin
          m_bad <= 1'b1;
          m_errs <= (m_errs == 32'hFFFF_FFFF) ? m_errs : m_errs + 1;
          if (!m_seen) begin
            m_seen <= 1'b1; m_fbeat <= m_beats; m_fdata <= wdata[15:0];
          end
        end
        if (t_last) begin
          m_phase <= 2'd2;
          m_resp  <= (m_bad || t_bad) ? 2'd2 : 2'd0;
        end
      end else if (m_phase == 2'd2 && bready) begin
        m_bursts <= m_bursts + 1;
        m_phase  <= 2'd0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("awready", 64'(awready), 64'(m_phase == 2'd0));
      chk("wready", 64'(wready), 64'(m_phase == 2'd1));
      chk("bvalid", 64'(bvalid), 64'(m_phase == 2'd2));
      if (m_phase == 2'd2) chk("bresp", 64'(bresp), 64'(m_resp));
      chk("last_awaddr", last_awaddr, m_addr);
      chk("burst_count", 64'(burst_count), 64'(m_bursts));
      chk("beat_count", 64'(beat_count), 64'(m_beats));
      chk("error_count", 64'(error_count), 64'(m_errs));
      chk("first_err_beat", 64'(first_err_beat), 64'(m_fbeat));
      chk("first_err_data", 64'(first_err_data), 64'(m_fdata));
      chk("error_seen", 64'(error_seen), 64'(m_seen));
    end
  end

  // ---------------- drivers (enter and leave at posedge+1) ----------------
  task automatic send_aw(input logic [63:0] a, input logic [7:0] len);
    int n = 0;
    logic hs = 1'b0;
    awaddr = a; awlen = len; awvalid = 1'b1;
    do begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 1000);
    awvalid = 1'b0;
    if (!hs) timeout("aw_wait");
  endtask

  task automatic send_w(input logic [15:0] word, input logic last, input logic strb_bad);
    int n = 0;
    logic hs = 1'b0;
    wdata = {32{word}}; wstrb = strb_bad ? ~64'd1 : {64{1'b1}}; wlast = last; wvalid = 1'b1;
    do begin
      @(negedge clk); hs = wready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 1000);
    wvalid = 1'b0; wlast = 1'b0;
    if (!hs) timeout("w_wait");
  endtask

  task automatic get_b(output logic [1:0] resp);
    int n = 0;
    logic hs = 1'b0;
    resp = 2'd3;
    bready = 1'b1;
    do begin
      @(negedge clk); hs = bvalid; resp = bresp;
      @(posedge clk); #1; n++;
    end while (!hs && n < 1000);
    if (!hs) timeout("b_wait");
  endtask

  task automatic run_burst(input logic [63:0] a, input int nbeats, input logic [15:0] first,
                           input logic [1:0] exp_resp);
    logic [1:0] r;
    send_aw(a, 8'(nbeats - 1));
    for (int i = 0; i < nbeats; i++) send_w(first + 16'(i), i == nbeats - 1, 1'b0);
    get_b(r);
    chk("burst_bresp", 64'(r), 64'(exp_resp));
    $display("burst addr=0x%0h beats=%0d first=0x%0h bresp=%0d", a, nbeats, first, r);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    logic [1:0] r;
    reset = 1'b1; awaddr = 0; awlen = 0; awvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    wvalid = 0; bready = 1'b1; clear = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    @(posedge clk); #1;

    // W presented before AW must wait
    wdata = {32{16'd1}}; wstrb = '1; wvalid = 1'b1;
    repeat (2) begin @(negedge clk); chk("early_w_wready", 64'(wready), 64'd0); end
    @(posedge clk); #1;

    // three clean 4-beat bursts, data 1..12
    for (int b = 0; b < 3; b++) run_burst(64'h1000 * (b + 1), 4, 16'(1 + 4 * b), 2'd0);
    chk("t1_burst_count", 64'(burst_count), 64'd3);
    chk("t1_beat_count", 64'(beat_count), 64'd12);
    chk("t1_error_count", 64'(error_count), 64'd0);
    chk("t1_error_seen", 64'(error_seen), 64'd0);
    chk("t1_last_awaddr", last_awaddr, 64'h3000);

    // corrupted third beat
    pulse_clear();
    send_aw(64'hA000, 8'd3);
    send_w(16'd1, 1'b0, 1'b0); send_w(16'd2, 1'b0, 1'b0);
    send_w(16'd9, 1'b0, 1'b0); send_w(16'd4, 1'b1, 1'b0);
    get_b(r);
    $display("burst addr=0xa000 beats=4 corrupted bresp=%0d", r);
    chk("t3_bresp", 64'(r), 64'd2);
    chk("t3_error_count", 64'(error_count), 64'd1);
    chk("t3_first_err_beat", 64'(first_err_beat), 64'd2);
    chk("t3_first_err_data", 64'(first_err_data), 64'h9);
    chk("t3_error_seen", 64'(error_seen), 64'd1);
    run_burst(64'hB000, 4, 16'd5, 2'd0);
    chk("t3_next_error_count", 64'(error_count), 64'd1);

    // misplaced WLAST: early on beat 2, missing on beat 4
    pulse_clear();
    send_aw(64'hC000, 8'd3);
    send_w(16'd1, 1'b0, 1'b0); send_w(16'd2, 1'b1, 1'b0);
    send_w(16'd3, 1'b0, 1'b0); send_w(16'd4, 1'b0, 1'b0);
    get_b(r);
    $display("burst addr=0xc000 beats=4 bad wlast bresp=%0d", r);
    chk("t4_bresp", 64'(r), 64'd2);
    chk("t4_error_count", 64'(error_count), 64'd2);
    chk("t4_beat_count", 64'(beat_count), 64'd4);
    chk("t4_first_err_beat", 64'(first_err_beat), 64'd1);
    @(negedge clk); chk("t4_awready", 64'(awready), 64'd1);
    @(posedge clk); #1;

    // BREADY stalled, clear pulsed mid-burst
    bready = 1'b0;
    send_aw(64'hD000, 8'd3);
    send_w(16'd5, 1'b0, 1'b0);
    clear = 1'b1;
    send_w(16'd6, 1'b0, 1'b0);
    clear = 1'b0;
    send_w(16'd7, 1'b0, 1'b0); send_w(16'd8, 1'b1, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("t5_bvalid_hold", 64'(bvalid), 64'd1);
      chk("t5_bresp_hold", 64'(bresp), 64'd0);
      @(posedge clk); #1;
    end
    get_b(r);
    $display("burst addr=0xd000 beats=4 stalled bresp=%0d", r);
    chk("t5_burst_count_pre", 64'(burst_count), 64'd2);
    @(posedge clk); #1;
    chk("t5_burst_count_cleared", 64'(burst_count), 64'd0);
    run_burst(64'hE000, 1, 16'd1, 2'd0);
    chk("t5_error_count", 64'(error_count), 64'd0);

    // wrap of expected word through 0
    pulse_clear();
    for (int b = 0; b < 255; b++) run_burst(64'h10000 + 64'(b), 256, 16'(1 + 256 * b), 2'd0);
    run_burst(64'h20000, 239, 16'(1 + 256 * 255), 2'd0);
    run_burst(64'h30000, 256, 16'hFFF0, 2'd0);
    chk("t2_error_count", 64'(error_count), 64'd0);
    chk("t2_beat_count", 64'(beat_count), 64'd65775);
    chk("t2_burst_count", 64'(burst_count), 64'd257);

    // asynchronous reset mid-burst
    send_aw(64'hF000, 8'd7);
    send_w(16'h00F0, 1'b0, 1'b0); send_w(16'h00F1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t6_awready", 64'(awready), 64'd1);
    chk("t6_wready", 64'(wready), 64'd0);
    chk("t6_bvalid", 64'(bvalid), 64'd0);
    chk("t6_beat_count", 64'(beat_count), 64'd0);
    chk("t6_burst_count", 64'(burst_count), 64'd0);
    chk("t6_last_awaddr", last_awaddr, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    run_burst(64'h100, 1, 16'd1, 2'd0);
    chk("t6_error_count", 64'(error_count), 64'd0);
    chk("t6_beat_count_after", 64'(beat_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
